// File: rtl/conv_window_mac.sv
// rtl/conv_window_mac.sv - sequential MAC consumer of the convolution window handshake
// One multiplier walks the k x k window against the kernel SRAM and writes one normalised pixel per window.
module conv_window_mac #(
  parameter int MAX_KERNAL   = 31,
  parameter int X_MAX        = 60,
  parameter int Y_MAX        = 60,
  parameter int PIXEL_DEPTH  = 8,
  parameter int WEIGHT_DEPTH = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic [7:0]                                    kernel_size,
  input  logic [4:0]                                    norm_shift,
  output logic                                          new_trans,
  output logic                                          new_sample_req,
  input  logic                                          new_sample_ready,
  input  logic [MAX_KERNAL*MAX_KERNAL*PIXEL_DEPTH-1:0]  working_memory,
  output logic                                          update_pos,
  input  logic [$clog2(X_MAX)-1:0]                      curr_x,
  input  logic [$clog2(Y_MAX)-1:0]                      curr_y,
  input  logic                                          end_pos,
  output logic                                          ren_kern,
  output logic [$clog2(MAX_KERNAL)-1:0]                 kx_addr,
  output logic [$clog2(MAX_KERNAL)-1:0]                 ky_addr,
  input  logic [WEIGHT_DEPTH-1:0]                       rdat_kern,
  output logic                                          wen_out,
  output logic [$clog2(X_MAX):0]                        x_addr_out,
  output logic [$clog2(Y_MAX):0]                        y_addr_out,
  output logic [PIXEL_DEPTH-1:0]                        wdat_out,
  output logic                                          busy,
  output logic                                          done
);

  localparam int KW      = $clog2(MAX_KERNAL);
  localparam int ACC_W   = PIXEL_DEPTH + WEIGHT_DEPTH + $clog2(MAX_KERNAL*MAX_KERNAL);
  localparam int MAX_PIX = (2**PIXEL_DEPTH) - 1;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_TRANS = 4'd1;
  localparam logic [3:0] S_WAIT  = 4'd2;
  localparam logic [3:0] S_REQ   = 4'd3;
  localparam logic [3:0] S_MAC   = 4'd4;
  localparam logic [3:0] S_DRAIN = 4'd5;
  localparam logic [3:0] S_WRITE = 4'd6;
  localparam logic [3:0] S_NEXT  = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  // Window is flattened x-major: pixel [x][y] sits at slice (x*MAX_KERNAL + y).
  logic [PIXEL_DEPTH-1:0] win [MAX_KERNAL][MAX_KERNAL];
  for (genvar gx = 0; gx < MAX_KERNAL; gx++) begin : g_wx
    for (genvar gy = 0; gy < MAX_KERNAL; gy++) begin : g_wy
      assign win[gx][gy] = working_memory[(gx*MAX_KERNAL + gy)*PIXEL_DEPTH +: PIXEL_DEPTH];
    end
  end

  logic [3:0]             state_q, state_d;
  logic [KW-1:0]          km1_q, km1_d;
  logic [4:0]             shift_q, shift_d;
  logic [KW-1:0]          x_q, x_d, y_q, y_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [PIXEL_DEPTH-1:0] pix_q, pix_d;
  logic                   mac_vld_q, mac_vld_d;
  logic                   skip_q, skip_d;
  logic                   new_trans_q, new_sample_req_q, update_pos_q, wen_q, done_q, busy_q;

  always_comb begin
    state_d   = state_q;
    km1_d     = km1_q;
    shift_d   = shift_q;
    x_d       = x_q;
    y_d       = y_q;
    acc_d     = acc_q;
    pix_d     = pix_q;
    mac_vld_d = (state_q == S_MAC);
    // The pixel register and rdat_kern both trail the issued address by one cycle.
    if (mac_vld_q) begin
      acc_d = acc_q + ACC_W'(pix_q) * ACC_W'(rdat_kern);
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_TRANS;
          shift_d = norm_shift;
          if (kernel_size == 8'd0) begin
            km1_d = '0;
          end else if (kernel_size > 8'(MAX_KERNAL)) begin
            km1_d = KW'(MAX_KERNAL - 1);
          end else begin
            km1_d = KW'(kernel_size - 8'd1);
          end
        end
      end
      S_TRANS: begin
        acc_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!skip_q && new_sample_ready) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        acc_d   = '0;
        x_d     = '0;
        y_d     = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        pix_d = win[x_q][y_q];
        if (x_q == km1_q) begin
          x_d = '0;
          if (y_q == km1_q) begin
            state_d = S_DRAIN;
          end else begin
            y_d = y_q + 1'b1;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: state_d = end_pos ? S_DONE : S_NEXT;
      S_NEXT:  state_d = S_WAIT;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Window memory's ready lags a cycle, so the first WAIT cycle sees a stale value.
    skip_d = (state_d == S_WAIT) && (state_q != S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      km1_q            <= '0;
      shift_q          <= '0;
      x_q              <= '0;
      y_q              <= '0;
      acc_q            <= '0;
      pix_q            <= '0;
      mac_vld_q        <= 1'b0;
      skip_q           <= 1'b0;
      new_trans_q      <= 1'b0;
      new_sample_req_q <= 1'b0;
      update_pos_q     <= 1'b0;
      wen_q            <= 1'b0;
      done_q           <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      km1_q            <= km1_d;
      shift_q          <= shift_d;
      x_q              <= x_d;
      y_q              <= y_d;
      acc_q            <= acc_d;
      pix_q            <= pix_d;
      mac_vld_q        <= mac_vld_d;
      skip_q           <= skip_d;
      new_trans_q      <= (state_d == S_TRANS);
      new_sample_req_q <= (state_d == S_REQ);
      update_pos_q     <= (state_d == S_NEXT);
      wen_q            <= (state_d == S_WRITE);
      done_q           <= (state_d == S_DONE);
      busy_q           <= (state_d != S_IDLE);
    end
  end

  logic [ACC_W-1:0]       shifted;
  logic [PIXEL_DEPTH-1:0] sat_pix;

  always_comb begin
    shifted = acc_q >> shift_q;
    sat_pix = (shifted > ACC_W'(MAX_PIX)) ? {PIXEL_DEPTH{1'b1}} : shifted[PIXEL_DEPTH-1:0];
  end

  assign new_trans      = new_trans_q;
  assign new_sample_req = new_sample_req_q;
  assign update_pos     = update_pos_q;
  assign wen_out        = wen_q;
  assign done           = done_q;
  assign busy           = busy_q;
  assign ren_kern       = (state_q == S_MAC);
  assign kx_addr        = ren_kern ? x_q : '0;
  assign ky_addr        = ren_kern ? y_q : '0;
  assign wdat_out       = wen_q ? sat_pix : '0;
  assign x_addr_out     = wen_q ? {1'b0, curr_x} : '0;
  assign y_addr_out     = wen_q ? {1'b0, curr_y} : '0;

endmodule

// File: tb/tb_conv_window_mac.sv
// tb/tb_conv_window_mac.sv - directed bench for conv_window_mac
// Models the window memory, position scanner and kernel SRAM around the MAC.
module tb_conv_window_mac;
  localparam int MK = 31;
  localparam int PD = 8;

  logic              clk = 1'b0;
  logic              rst, start, new_trans, new_sample_req, new_sample_ready;
  logic [7:0]        kernel_size;
  logic [4:0]        norm_shift;
  logic [MK*MK*PD-1:0] working_memory;
  logic              update_pos, end_pos, ren_kern, wen_out, busy, done;
  logic [5:0]        cx, cy;
  logic [4:0]        kx_addr, ky_addr;
  logic [7:0]        rdat_kern, wdat_out;
  logic [6:0]        x_addr_out, y_addr_out;

  always #5 clk = ~clk;

  conv_window_mac dut (
    .clk(clk), .rst(rst), .start(start), .kernel_size(kernel_size), .norm_shift(norm_shift),
    .new_trans(new_trans), .new_sample_req(new_sample_req), .new_sample_ready(new_sample_ready),
    .working_memory(working_memory), .update_pos(update_pos), .curr_x(cx), .curr_y(cy),
    .end_pos(end_pos), .ren_kern(ren_kern), .kx_addr(kx_addr), .ky_addr(ky_addr),
    .rdat_kern(rdat_kern), .wen_out(wen_out), .x_addr_out(x_addr_out), .y_addr_out(y_addr_out),
    .wdat_out(wdat_out), .busy(busy), .done(done)
  );

  int ready_en, mode, fill_pix, wt_val, img_w, img_h;
  logic [7:0] img [4];
  int n_checks = 0, n_fail = 0;
  int n_done = 0, n_upd = 0, n_ren = 0, n_overlap = 0, n_idle_bad = 0, cyc = 0, req_cyc = 0;
  int wq_dat[$], wq_x[$], wq_y[$], wq_lat[$];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Position scanner, ready handshake and kernel SRAM (mode 2: w = 1 + kx + 4*ky)
  assign end_pos = (int'(cx) == img_w - 1) && (int'(cy) == img_h - 1);
  always @(posedge clk) begin
    if (rst || new_trans) begin
      cx <= '0;
      cy <= '0;
    end else if (update_pos) begin
      if (int'(cx) == img_w - 1) begin
        cx <= '0;
        cy <= cy + 6'd1;
      end else begin
        cx <= cx + 6'd1;
      end
    end
    if (rst || new_trans || update_pos || new_sample_req) new_sample_ready <= 1'b0;
    else new_sample_ready <= (ready_en != 0);
    if (!ren_kern) rdat_kern <= 8'd0;
    else if (mode == 2) rdat_kern <= 8'(1 + int'(kx_addr) + 4 * int'(ky_addr));
    else rdat_kern <= 8'(wt_val);
  end

  // Window contents (mode 0: 2x2 image, 1: uniform fill, 2: pixel = x + 2y + 1)
  always_comb begin
    working_memory = '0;
    for (int x = 0; x < MK; x++) begin
      for (int y = 0; y < MK; y++) begin
        if (mode == 0) working_memory[(x*MK+y)*PD +: PD] = img[{cy[0], cx[0]}];
        else if (mode == 2) working_memory[(x*MK+y)*PD +: PD] = 8'(x + 2*y + 1);
        else working_memory[(x*MK+y)*PD +: PD] = 8'(fill_pix);
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (new_sample_req) req_cyc = cyc;
    if (wen_out) begin
      wq_dat.push_back(int'(wdat_out));
      wq_x.push_back(int'(x_addr_out));
      wq_y.push_back(int'(y_addr_out));
      wq_lat.push_back(cyc - req_cyc);
    end
    if (update_pos) n_upd++;
    if (done) n_done++;
    if (ren_kern) n_ren++;
    if ($countones({new_trans, new_sample_req, update_pos, wen_out, done}) > 1) n_overlap++;
    if (!wen_out && (wdat_out != 0 || x_addr_out != 0 || y_addr_out != 0)) n_idle_bad++;
  end

  task automatic launch(input int k, input int sh);
    kernel_size = 8'(k);
    norm_shift  = 5'(sh);
    wq_dat.delete(); wq_x.delete(); wq_y.delete(); wq_lat.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", t < 4000, 1);
    @(negedge clk);
  endtask

  task automatic run(input int k, input int sh);
    launch(k, sh);
    wait_done();
  endtask

  task automatic expect1(input string tag, input int val);
    check({tag, "_nwr"}, wq_dat.size(), 1);
    check({tag, "_dat"}, (wq_dat.size() > 0) ? wq_dat[0] : -1, val);
  endtask

  task automatic wait_ren();
    int t = 0;
    while (!ren_kern && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("ren_seen", t < 100, 1);
  endtask

  int d0, u0, r0, bad, lo;
  int exp_dat[4] = '{5, 6, 7, 8};
  int exp_x[4]   = '{0, 1, 0, 1};
  int exp_y[4]   = '{0, 0, 1, 1};

  initial begin
    img[0] = 8'd5; img[1] = 8'd6; img[2] = 8'd7; img[3] = 8'd8;
    rst = 1'b1; start = 1'b0; kernel_size = 8'd0; norm_shift = 5'd0;
    ready_en = 1; mode = 1; fill_pix = 10; wt_val = 1; img_w = 1; img_h = 1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pulses", {new_trans, new_sample_req, update_pos, wen_out}, 0);
    check("rst_ren", {ren_kern, kx_addr, ky_addr}, 0);
    check("rst_wr", {wdat_out, x_addr_out, y_addr_out}, 0);
    rst = 1'b0;
    @(negedge clk);

    // 2x2 image, k=1
    mode = 0; img_w = 2; img_h = 2; wt_val = 1;
    d0 = n_done; u0 = n_upd;
    run(1, 0);
    check("img_nwr", wq_dat.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("img_dat%0d", i), (i < wq_dat.size()) ? wq_dat[i] : -1, exp_dat[i]);
      check($sformatf("img_x%0d", i), (i < wq_x.size()) ? wq_x[i] : -1, exp_x[i]);
      check($sformatf("img_y%0d", i), (i < wq_y.size()) ? wq_y[i] : -1, exp_y[i]);
    end
    check("img_upd", n_upd - u0, 3);
    check("img_done", n_done - d0, 1);

    // k=3 uniform windows
    mode = 1; img_w = 1; img_h = 1; fill_pix = 10; wt_val = 1;
    d0 = n_done; u0 = n_upd; r0 = n_ren;
    run(3, 0);
    expect1("k3_s0", 90);
    check("k3_lat", (wq_lat.size() > 0) ? wq_lat[0] : -1, 11);
    check("k3_ren", n_ren - r0, 9);
    check("k3_noupd", n_upd - u0, 0);
    check("k3_done", n_done - d0, 1);
    run(3, 3);
    expect1("k3_s3", 11);
    fill_pix = 255; wt_val = 255;
    run(3, 0);
    expect1("sat_s0", 255);
    run(3, 16);
    expect1("sat_s16", 8);

    // k=2 asymmetric pixels and weights: 1*1 + 2*2 + 3*5 + 4*6
    mode = 2; r0 = n_ren;
    run(2, 0);
    expect1("pat_k2", 44);
    check("pat_ren", n_ren - r0, 4);

    // Clamping of kernel_size
    mode = 1; fill_pix = 10; wt_val = 1; r0 = n_ren;
    run(0, 0);
    expect1("k0", 10);
    check("k0_ren", n_ren - r0, 1);
    fill_pix = 1; r0 = n_ren;
    run(40, 2);
    expect1("k40", 240);
    check("k40_ren", n_ren - r0, 961);

    // Ready held low in WAIT
    fill_pix = 10; ready_en = 0; bad = 0; lo = 0;
    launch(3, 0);
    repeat (20) begin
      @(negedge clk);
      if (new_sample_req || ren_kern || wen_out || update_pos) bad++;
      if (!busy) lo++;
    end
    check("hold_noact", bad, 0);
    check("hold_busy", lo, 0);
    ready_en = 1;
    wait_done();
    expect1("hold_res", 90);

    // start pulsed mid-MAC
    d0 = n_done; r0 = n_ren;
    launch(3, 0);
    wait_ren();
    kernel_size = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    expect1("startmac", 90);
    check("startmac_ren", n_ren - r0, 9);
    check("startmac_done", n_done - d0, 1);

    // rst mid-MAC then golden rerun
    launch(3, 0);
    wait_ren();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_busy", busy, 0);
    check("mrst_outs", {new_trans, new_sample_req, update_pos, wen_out, done, ren_kern}, 0);
    check("mrst_wr", {wdat_out, x_addr_out, y_addr_out, kx_addr, ky_addr}, 0);
    rst = 1'b0;
    @(negedge clk);
    run(3, 0);
    expect1("mrst_gold", 90);

    check("pulse_overlap", n_overlap, 0);
    check("idle_wr_zero", n_idle_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_window_mac.md
# conv_window_mac

Consumer end of the convolution window handshake. Drives `new_trans` and `new_sample_req` toward the window-memory block and advances the scan through `pixel_pos`. For every window it receives, it computes a weighted sum against kernel coefficients read from the kernel SRAM, normalises the result, and writes one output pixel to the output SRAM. The block sits between the window memory and the output image SRAM, replacing a fully parallel multiplier array with one sequential MAC.

## Interface
- `MAX_KERNAL`, 31: largest supported kernel edge; matches the window-memory parameter.
- `X_MAX`, 60: image width bound.
- `Y_MAX`, 60: image height bound.
- `PIXEL_DEPTH`, 8: pixel width.
- `WEIGHT_DEPTH`, 8: unsigned kernel coefficient width.
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  begin a new image pass; sampled in IDLE only.
- `kernel_size`  in  8  kernel edge k; captured at start.
- `norm_shift`  in  5  right-shift applied to the sum; captured at start.
- `new_trans`  out  1  one-cycle pulse that resets the window memory and `pixel_pos`.
- `new_sample_req`  out  1  one-cycle pulse; window memory latches `working_memory` on this edge.
- `new_sample_ready`  in  1  window memory has a complete window.
- `working_memory`  in  MAX_KERNAL*MAX_KERNAL*PIXEL_DEPTH  window, indexed [x][y].
- `update_pos`  out  1  one-cycle pulse that advances `pixel_pos`.
- `curr_x`  in  $clog2(X_MAX)  current window origin x.
- `curr_y`  in  $clog2(Y_MAX)  current window origin y.
- `end_pos`  in  1  current position is the last of the scan.
- `ren_kern`  out  1  kernel SRAM read enable.
- `kx_addr`, `ky_addr`  out  $clog2(MAX_KERNAL) each  kernel coefficient address.
- `rdat_kern`  in  WEIGHT_DEPTH  coefficient; valid the cycle after the address is issued.
- `wen_out`  out  1  output SRAM write strobe.
- `x_addr_out`  out  $clog2(X_MAX)+1  output write address, x.
- `y_addr_out`  out  $clog2(Y_MAX)+1  output write address, y.
- `wdat_out`  out  PIXEL_DEPTH  output pixel.
- `busy`  out  1  high in every state other than IDLE.
- `done`  out  1  one-cycle pulse at the end of the pass.

## Operation
- **States:** IDLE, TRANS, WAIT, REQ, MAC, DRAIN, WRITE, NEXT, DONE.
- **IDLE:** on `start`, capture `kernel_size` as k and `norm_shift`, then go to TRANS.
- **k clamping:** k=0 becomes 1; k>MAX_KERNAL becomes MAX_KERNAL.
- **TRANS:** assert `new_trans` for one cycle, clear the accumulator, go to WAIT.
- **WAIT:** hold until `new_sample_ready`=1, then go to REQ.
  - Ignore `new_sample_ready` in the first WAIT cycle after NEXT or TRANS; the ready signal from the window memory lags by one cycle.
- **REQ:** assert `new_sample_req` for one cycle, clear the accumulator, reset the x and y index counters to 0, go to MAC.
- **MAC:** runs for k*k cycles.
  - Each cycle issue `ren_kern`=1 with `kx_addr`=x and `ky_addr`=y.
  - x is the inner loop, 0..k-1; y is the outer loop.
  - Register the matching pixel `working_memory[x][y]` for one cycle so it aligns with `rdat_kern`.
  - From the second MAC cycle on, accumulate `acc += pixel_d * rdat_kern`.
  - After issuing (k-1,k-1), go to DRAIN.
- **DRAIN:** perform the final accumulate, go to WRITE.
- **WRITE:** for one cycle, drive `wen_out`=1, `x_addr_out`=`curr_x`, `y_addr_out`=`curr_y`, and `wdat_out` = min(acc >> norm_shift, 2^PIXEL_DEPTH-1).
  - If `end_pos`=1, go to DONE; otherwise go to NEXT.
- **NEXT:** pulse `update_pos` for one cycle, go to WAIT.
- **DONE:** pulse `done` for one cycle, go to IDLE.
- **Accumulator:** unsigned, PIXEL_DEPTH+WEIGHT_DEPTH+$clog2(MAX_KERNAL*MAX_KERNAL) bits (26 at the defaults). It cannot overflow.
- **`start` while busy:** ignored.
- **`rst`:** takes effect at any state. Next cycle the FSM is in IDLE and the accumulator and counters are 0.

## Timing
- **Reset values:** every output is 0, including `busy` and `done`.
- **Output style:** `new_trans`, `new_sample_req`, `update_pos`, `wen_out` and `done` are registered single-cycle pulses and are never asserted together.
- **`ren_kern`:** high only in MAC.
- **`wdat_out` and the write addresses:** 0 whenever `wen_out`=0.
- **Per-pixel cost:** REQ→WRITE takes 1 + k*k + 1 cycles; WRITE→WAIT adds 2 cycles (WRITE, NEXT).
- **Last pixel:** `done` fires 1 cycle after the WRITE of the last pixel.
- **Window validity:** `working_memory` is read only in MAC, starting the cycle after REQ.
- **Kernel read latency:** exactly 1 cycle. There is no stall input; the kernel SRAM must respond every cycle.

## Test plan
- k=1, weight 1, shift 0, 2x2 image model of {5,6,7,8} → four writes with `wdat_out` 5,6,7,8 at the matching (`curr_x`,`curr_y`), then one `done` pulse.
- k=3, all weights 1, window of all 10s: shift 0 → `wdat_out`=90; shift 3 → `wdat_out`=11. The `wen_out` pulse arrives 11 cycles after `new_sample_req`.
- k=3, weights 255, pixels 255, shift 0 → `wdat_out`=255 (saturated). With shift 16 → 8 (585225>>16).
- `new_sample_ready` held low for 20 cycles in WAIT → no `new_sample_req`, `ren_kern`, `wen_out` or `update_pos`; `busy`=1 throughout.
- `rst` asserted mid-MAC → next cycle all outputs 0 and `busy`=0. A following `start` reproduces the golden result exactly.
- `start` pulsed during MAC → ignored. `end_pos`=1 at WRITE → `done` next cycle with no `update_pos`. `kernel_size`=0 → behaves as k=1.
